mem_rd_arbiter: RTL and testbench
=================================

# mem_rd_arbiter

Shares the core's single 64-bit physical-memory read port between the instruction-fetch requester and the load/store requester. It sequences one outstanding read at a time through an IDLE/REQ/WAIT/RESP state machine. It extracts the 32-bit instruction from the 64-bit beat for fetches and faults illegal fetch addresses without touching memory. It sits between the fetch/LSU stages and the memory-access wrapper.

## Interface
- STARVE_MAX, 4: maximum consecutive load/store grants while a fetch is pending; legal range 1..15.
- clk  in  1  single clock, rising edge
- reset  in  1  asynchronous, active-low reset
- if_req_valid  in  1  fetch request valid
- if_req_ready  out  1  fetch request accepted this cycle
- if_addr  in  64  fetch PC
- if_resp_valid  out  1  one-cycle fetch response pulse
- if_resp_inst  out  32  fetched instruction
- if_resp_fault  out  1  fetch faulted; qualified by if_resp_valid
- ls_req_valid  in  1  load request valid
- ls_req_ready  out  1  load request accepted this cycle
- ls_addr  in  64  load address
- ls_resp_valid  out  1  one-cycle load response pulse
- ls_resp_data  out  64  raw 64-bit aligned beat
- mem_req_valid  out  1  memory read request
- mem_req_ready  in  1  memory accepts request
- mem_addr  out  64  8-byte-aligned address {addr[63:3],3'b000}
- mem_resp_valid  in  1  read data valid
- mem_resp_data  in  64  read data
- busy  out  1  state != IDLE

## Operation
- **States:** IDLE, REQ, WAIT, RESP. Only one transaction is in flight at a time.
- **IDLE:**
  - The winner is chosen combinationally, and only the winner's *_req_ready is driven to 1. Both readies are 0 in every other state.
  - Handshake fires on valid & ready. The fire captures the address, the owner (IF/LS) and the fault flag, then moves to REQ.
- **Fetch fault:**
  - A fetch with if_addr == 0 or if_addr[1:0] != 0 faults.
  - A faulting fetch goes IDLE -> RESP directly. No memory request is issued.
  - The response carries if_resp_fault=1 and if_resp_inst=0.
- **REQ:** mem_req_valid=1 with mem_addr taken from the captured address. Move to WAIT on mem_req_ready.
- **WAIT:** On mem_resp_valid, register mem_resp_data and move to RESP. mem_resp_valid is ignored in every state other than WAIT.
- **RESP:**
  - Exactly one of if_resp_valid or ls_resp_valid is 1, selected by owner. Return to IDLE next cycle.
  - if_resp_inst = captured_addr[2] ? data[63:32] : data[31:0].
  - ls_resp_data is the full 64-bit beat.
- **Arbitration:**
  - Load/store has default priority over fetch.
  - A streak counter increments when LS is granted while if_req_valid=1.
  - The streak counter clears to 0 when IF is granted or when IF is not valid at an LS grant.
  - When streak == STARVE_MAX and both requesters are valid, IF wins.
  - The streak counter saturates; it never wraps.

## Timing
- **Reset values:** All outputs are 0 on reset. State is IDLE and the streak counter is 0.
- **Reset mid-operation:** Asserting reset at any time drops the transaction in flight with no response pulse. A memory response arriving after reset is ignored.
- **Latency (cycles relative to accept at cycle 0):**
  - mem_req_valid rises at cycle 1.
  - If mem_req_ready=1 at cycle 1 and mem_resp_valid=1 at cycle 2, the response pulse appears at cycle 3.
  - Minimum round trip is 3 cycles. A fault responds at cycle 1.
- **Throughput:** The next accept can occur in the cycle after RESP, so the best case is 4 cycles per transaction.
- **Request stability:** mem_req_valid stays asserted with mem_addr stable until mem_req_ready is seen. Requester addresses need only be valid in the accept cycle.
- **Response outputs:** Response data outputs are registered and stable during the pulse. They hold their last value otherwise.

## Test plan
- **Single fetch:** reset, then IF request to 0x8000_0004, with memory ready immediately and returning 0x1111_2222_3333_4444 one cycle later -> if_resp_valid at cycle 3 with inst 0x1111_2222; mem_addr = 0x8000_0000.
- **Fetch faults:**
  - IF addr 0x0 -> if_resp_valid at cycle 1, fault=1, inst=0, mem_req_valid never asserted.
  - IF addr 0x8000_0002 -> same fault response.
- **Priority and starvation:** IF and LS both held valid continuously with STARVE_MAX=4 -> grant order LS,LS,LS,LS,IF,LS,...
- **Backpressure:** mem_req_ready held 0 for 5 cycles, mem_resp delayed 3 cycles -> mem_addr stable throughout, exactly one ls_resp_valid pulse with the correct 64-bit data, and both readies 0 while busy.
- **Reset mid-transaction:** reset asserted in WAIT, then mem_resp_valid pulsed after release -> no response pulse, busy=0, and the next IF request completes normally.

Source files
------------

// File: rtl/mem_rd_arbiter.sv
// Arbitrates the single 64-bit memory read port between instruction fetch and load/store,
// one outstanding read at a time, with fetch-starvation protection and fetch fault screening.
module mem_rd_arbiter #(
    parameter int unsigned STARVE_MAX = 4
) (
    input  logic        clk,
    input  logic        reset,
    input  logic        if_req_valid,
    output logic        if_req_ready,
    input  logic [63:0] if_addr,
    output logic        if_resp_valid,
    output logic [31:0] if_resp_inst,
    output logic        if_resp_fault,
    input  logic        ls_req_valid,
    output logic        ls_req_ready,
    input  logic [63:0] ls_addr,
    output logic        ls_resp_valid,
    output logic [63:0] ls_resp_data,
    output logic        mem_req_valid,
    input  logic        mem_req_ready,
    output logic [63:0] mem_addr,
    input  logic        mem_resp_valid,
    input  logic [63:0] mem_resp_data,
    output logic        busy
);

    localparam int unsigned ADDR_W   = 64;
    localparam int unsigned DATA_W   = 64;
    localparam int unsigned INST_W   = 32;
    localparam int unsigned STREAK_W = 4;
    localparam int unsigned OFFS_W   = 3;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        REQ  = 2'd1,
        WAIT = 2'd2,
        RESP = 2'd3
    } state_t;

    state_t                     state;
    state_t                     state_d;
    logic                       owner_if;
    logic                       sel_hi;
    logic [STREAK_W-1:0]        streak;
    logic                       streak_at_max;
    logic                       grant_if;
    logic                       grant_ls;
    logic                       if_fault;
    logic [ADDR_W-1:OFFS_W]     req_line;
    logic                       unused_bits;

    // Load/store wins by default; a pending fetch wins once the LS streak hits its limit.
    assign streak_at_max = (streak == STREAK_W'(STARVE_MAX));
    assign grant_if      = if_req_valid && (!ls_req_valid || streak_at_max);
    assign grant_ls      = ls_req_valid && !grant_if;
    assign if_fault      = (if_addr == '0) || (if_addr[1:0] != 2'b00);
    assign req_line      = if_req_ready ? if_addr[ADDR_W-1:OFFS_W] : ls_addr[ADDR_W-1:OFFS_W];
    assign unused_bits   = ^ls_addr[OFFS_W-1:0];

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            state <= IDLE;
        end else begin
            state <= state_d;
        end
    end

    // Next state and the accept handshakes (readies only ever high in IDLE).
    always_comb begin
        state_d      = state;
        if_req_ready = 1'b0;
        ls_req_ready = 1'b0;
        case (state)
            IDLE: begin
                if_req_ready = grant_if;
                ls_req_ready = grant_ls;
                if (grant_if) begin
                    state_d = if_fault ? RESP : REQ;
                end else if (grant_ls) begin
                    state_d = REQ;
                end
            end
            REQ:     if (mem_req_ready)  state_d = WAIT;
            WAIT:    if (mem_resp_valid) state_d = RESP;
            RESP:    state_d = IDLE;
            default: state_d = IDLE;
        endcase
    end

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            owner_if      <= 1'b0;
            sel_hi        <= 1'b0;
            streak        <= '0;
            mem_req_valid <= 1'b0;
            mem_addr      <= '0;
            busy          <= 1'b0;
            if_resp_valid <= 1'b0;
            if_resp_inst  <= '0;
            if_resp_fault <= 1'b0;
            ls_resp_valid <= 1'b0;
            ls_resp_data  <= '0;
        end else begin
            mem_req_valid <= (state_d == REQ);
            busy          <= (state_d != IDLE);
            if_resp_valid <= (state_d == RESP) && ((state == IDLE) || owner_if);
            ls_resp_valid <= (state_d == RESP) && (state == WAIT) && !owner_if;

            if (if_req_ready || ls_req_ready) begin
                owner_if <= if_req_ready;
                sel_hi   <= if_addr[2];
                if (state_d == REQ) begin
                    mem_addr <= {req_line, OFFS_W'(0)};
                end
            end

            // Faulting fetch skips memory and answers straight from IDLE.
            if ((state == IDLE) && (state_d == RESP)) begin
                if_resp_fault <= 1'b1;
                if_resp_inst  <= '0;
            end

            if ((state == WAIT) && mem_resp_valid) begin
                if (owner_if) begin
                    if_resp_fault <= 1'b0;
                    if_resp_inst  <= sel_hi ? mem_resp_data[DATA_W-1:INST_W]
                                            : mem_resp_data[INST_W-1:0];
                end else begin
                    ls_resp_data <= mem_resp_data;
                end
            end

            if (ls_req_ready) begin
                if (!if_req_valid) begin
                    streak <= '0;
                end else if (!streak_at_max) begin
                    streak <= streak + STREAK_W'(1);
                end
            end else if (if_req_ready) begin
                streak <= '0;
            end
        end
    end

endmodule

// File: tb/tb_mem_rd_arbiter.sv
// Directed self-checking bench for mem_rd_arbiter: fetch path, faults, starvation,
// memory backpressure and reset in the middle of a transaction.
module tb_mem_rd_arbiter;

    logic        clk;
    logic        reset;
    logic        if_req_valid;
    logic        if_req_ready;
    logic [63:0] if_addr;
    logic        if_resp_valid;
    logic [31:0] if_resp_inst;
    logic        if_resp_fault;
    logic        ls_req_valid;
    logic        ls_req_ready;
    logic [63:0] ls_addr;
    logic        ls_resp_valid;
    logic [63:0] ls_resp_data;
    logic        mem_req_valid;
    logic        mem_req_ready;
    logic [63:0] mem_addr;
    logic        mem_resp_valid;
    logic [63:0] mem_resp_data;
    logic        busy;

    int checks = 0;
    int errors = 0;
    int ls_pulses = 0;
    int if_pulses = 0;
    int req_cycles = 0;

    mem_rd_arbiter #(.STARVE_MAX(4)) dut (
        .clk            (clk),
        .reset          (reset),
        .if_req_valid   (if_req_valid),
        .if_req_ready   (if_req_ready),
        .if_addr        (if_addr),
        .if_resp_valid  (if_resp_valid),
        .if_resp_inst   (if_resp_inst),
        .if_resp_fault  (if_resp_fault),
        .ls_req_valid   (ls_req_valid),
        .ls_req_ready   (ls_req_ready),
        .ls_addr        (ls_addr),
        .ls_resp_valid  (ls_resp_valid),
        .ls_resp_data   (ls_resp_data),
        .mem_req_valid  (mem_req_valid),
        .mem_req_ready  (mem_req_ready),
        .mem_addr       (mem_addr),
        .mem_resp_valid (mem_resp_valid),
        .mem_resp_data  (mem_resp_data),
        .busy           (busy)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // Running pulse/cycle counters; tests compare snapshots.
    always @(negedge clk) begin
        if (ls_resp_valid) ls_pulses++;
        if (if_resp_valid) if_pulses++;
        if (mem_req_valid) req_cycles++;
    end

    task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
        checks++;
        if (got !== exp) begin
            errors++;
            $display("FAIL %s got %h expected %h", tag, got, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    // Fetch with memory ready at cycle 1 and data at cycle 2; response expected at cycle 3.
    task automatic run_fetch(input logic [63:0] addr, input logic [63:0] exp_maddr,
                             input logic [63:0] data, input logic [31:0] exp_inst);
        tick();
        if_req_valid = 1'b1;
        if_addr      = addr;
        #1;
        check("fetch_if_ready", 64'(if_req_ready), 64'd1);
        check("fetch_ls_ready", 64'(ls_req_ready), 64'd0);
        tick();
        if_req_valid  = 1'b0;
        mem_req_ready = 1'b1;
        #1;
        check("fetch_mem_req_c1", 64'(mem_req_valid), 64'd1);
        check("fetch_mem_addr", mem_addr, exp_maddr);
        check("fetch_busy_c1", 64'(busy), 64'd1);
        check("fetch_if_ready_busy", 64'(if_req_ready), 64'd0);
        tick();
        mem_req_ready  = 1'b0;
        mem_resp_valid = 1'b1;
        mem_resp_data  = data;
        #1;
        check("fetch_mem_req_c2", 64'(mem_req_valid), 64'd0);
        check("fetch_resp_early", 64'(if_resp_valid), 64'd0);
        tick();
        mem_resp_valid = 1'b0;
        #1;
        check("fetch_resp_c3", 64'(if_resp_valid), 64'd1);
        check("fetch_inst", 64'(if_resp_inst), 64'(exp_inst));
        check("fetch_fault", 64'(if_resp_fault), 64'd0);
        check("fetch_ls_resp", 64'(ls_resp_valid), 64'd0);
        tick();
        #1;
        check("fetch_resp_c4", 64'(if_resp_valid), 64'd0);
        check("fetch_idle", 64'(busy), 64'd0);
        check("fetch_inst_hold", 64'(if_resp_inst), 64'(exp_inst));
    endtask

    task automatic run_fault(input logic [63:0] addr);
        int r0;
        tick();
        if_req_valid = 1'b1;
        if_addr      = addr;
        #1;
        check("fault_if_ready", 64'(if_req_ready), 64'd1);
        r0 = req_cycles;
        tick();
        if_req_valid = 1'b0;
        #1;
        check("fault_resp_c1", 64'(if_resp_valid), 64'd1);
        check("fault_flag", 64'(if_resp_fault), 64'd1);
        check("fault_inst", 64'(if_resp_inst), 64'd0);
        check("fault_mem_req", 64'(mem_req_valid), 64'd0);
        tick();
        #1;
        check("fault_resp_c2", 64'(if_resp_valid), 64'd0);
        check("fault_idle", 64'(busy), 64'd0);
        check("fault_no_mem_req", 64'(req_cycles - r0), 64'd0);
    endtask

    initial begin
        int          n;
        int          p0;
        logic [5:0]  order;
        logic [5:0]  exp_order;

        reset          = 1'b0;
        if_req_valid   = 1'b0;
        if_addr        = '0;
        ls_req_valid   = 1'b0;
        ls_addr        = '0;
        mem_req_ready  = 1'b0;
        mem_resp_valid = 1'b0;
        mem_resp_data  = '0;

        // Reset values
        tick();
        tick();
        check("rst_busy", 64'(busy), 64'd0);
        check("rst_mem_req", 64'(mem_req_valid), 64'd0);
        check("rst_mem_addr", mem_addr, 64'd0);
        check("rst_if_resp", 64'(if_resp_valid), 64'd0);
        check("rst_ls_resp", 64'(ls_resp_valid), 64'd0);
        check("rst_inst", 64'(if_resp_inst), 64'd0);
        check("rst_ls_data", ls_resp_data, 64'd0);
        check("rst_fault", 64'(if_resp_fault), 64'd0);
        reset = 1'b1;
        tick();

        // Single fetch, upper word
        run_fetch(64'h0000_0000_8000_0004, 64'h0000_0000_8000_0000,
                  64'h1111_2222_3333_4444, 32'h1111_2222);

        // Fetch faults
        run_fault(64'h0);
        run_fault(64'h0000_0000_8000_0002);

        // Priority and starvation with both requesters held valid
        tick();
        if_req_valid   = 1'b1;
        if_addr        = 64'h0000_0000_8000_0008;
        ls_req_valid   = 1'b1;
        ls_addr        = 64'h0000_0000_0000_2000;
        mem_req_ready  = 1'b1;
        mem_resp_valid = 1'b1;
        mem_resp_data  = 64'h5555_6666_7777_8888;
        n     = 0;
        order = '0;
        for (int c = 0; c < 80 && n < 6; c++) begin
            #1;
            if (if_req_ready) begin
                order[n] = 1'b1;
                n++;
            end else if (ls_req_ready) begin
                order[n] = 1'b0;
                n++;
            end
            if (n < 6) tick();
        end
        tick();
        if_req_valid = 1'b0;
        ls_req_valid = 1'b0;
        for (int c = 0; c < 20 && busy; c++) tick();
        mem_req_ready  = 1'b0;
        mem_resp_valid = 1'b0;
        check("starve_grants", 64'(n), 64'd6);
        exp_order = 6'b01_0000;
        for (int i = 0; i < 6; i++) begin
            check($sformatf("starve_grant%0d", i), 64'(order[i]), 64'(exp_order[i]));
        end
        check("starve_drained", 64'(busy), 64'd0);

        // Backpressure: request stalled 5 cycles, response 3 cycles late
        p0 = ls_pulses;
        tick();
        ls_req_valid = 1'b1;
        ls_addr      = 64'h0000_0000_1000_0013;
        #1;
        check("bp_ls_ready", 64'(ls_req_ready), 64'd1);
        check("bp_if_ready", 64'(if_req_ready), 64'd0);
        for (int i = 1; i <= 5; i++) begin
            tick();
            if_req_valid   = 1'b1;
            if_addr        = 64'h0000_0000_8000_0000;
            mem_resp_valid = (i == 3);
            mem_resp_data  = 64'hDEAD_BEEF_DEAD_BEEF;
            #1;
            check("bp_mem_req_held", 64'(mem_req_valid), 64'd1);
            check("bp_mem_addr", mem_addr, 64'h0000_0000_1000_0010);
            check("bp_if_ready_busy", 64'(if_req_ready), 64'd0);
            check("bp_ls_ready_busy", 64'(ls_req_ready), 64'd0);
        end
        tick();
        mem_req_ready  = 1'b1;
        mem_resp_valid = 1'b0;
        #1;
        check("bp_mem_addr_c6", mem_addr, 64'h0000_0000_1000_0010);
        for (int i = 7; i <= 9; i++) begin
            tick();
            mem_req_ready = 1'b0;
            #1;
            check("bp_wait_no_req", 64'(mem_req_valid), 64'd0);
            check("bp_wait_busy", 64'(busy), 64'd1);
            check("bp_wait_ready", 64'(if_req_ready | ls_req_ready), 64'd0);
        end
        tick();
        mem_resp_valid = 1'b1;
        mem_resp_data  = 64'h0123_4567_89AB_CDEF;
        if_req_valid   = 1'b0;
        ls_req_valid   = 1'b0;
        #1;
        check("bp_resp_early", 64'(ls_resp_valid), 64'd0);
        tick();
        mem_resp_valid = 1'b0;
        #1;
        check("bp_ls_resp", 64'(ls_resp_valid), 64'd1);
        check("bp_ls_data", ls_resp_data, 64'h0123_4567_89AB_CDEF);
        check("bp_if_resp", 64'(if_resp_valid), 64'd0);
        tick();
        #1;
        check("bp_resp_end", 64'(ls_resp_valid), 64'd0);
        check("bp_idle", 64'(busy), 64'd0);
        check("bp_data_hold", ls_resp_data, 64'h0123_4567_89AB_CDEF);
        check("bp_one_pulse", 64'(ls_pulses - p0), 64'd1);

        // Reset while waiting for memory data
        tick();
        if_req_valid = 1'b1;
        if_addr      = 64'h0000_0000_8000_0010;
        #1;
        check("mid_if_ready", 64'(if_req_ready), 64'd1);
        tick();
        if_req_valid  = 1'b0;
        mem_req_ready = 1'b1;
        #1;
        check("mid_mem_req", 64'(mem_req_valid), 64'd1);
        tick();
        mem_req_ready = 1'b0;
        #1;
        reset = 1'b0;
        #1;
        p0 = if_pulses + ls_pulses;
        check("mid_rst_busy", 64'(busy), 64'd0);
        check("mid_rst_mem_req", 64'(mem_req_valid), 64'd0);
        check("mid_rst_mem_addr", mem_addr, 64'd0);
        check("mid_rst_inst", 64'(if_resp_inst), 64'd0);
        check("mid_rst_ls_data", ls_resp_data, 64'd0);
        tick();
        reset = 1'b1;
        tick();
        mem_resp_valid = 1'b1;
        mem_resp_data  = 64'hFFFF_0000_FFFF_0000;
        tick();
        mem_resp_valid = 1'b0;
        #1;
        check("mid_after_busy", 64'(busy), 64'd0);
        tick();
        check("mid_no_pulse", 64'(if_pulses + ls_pulses - p0), 64'd0);
        check("mid_inst_still0", 64'(if_resp_inst), 64'd0);

        run_fetch(64'h0000_0000_8000_0014, 64'h0000_0000_8000_0010,
                  64'hAAAA_BBBB_CCCC_DDDD, 32'hAAAA_BBBB);
        run_fetch(64'h0000_0000_8000_0018, 64'h0000_0000_8000_0018,
                  64'h9999_8888_7777_6666, 32'h7777_6666);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
